// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// FSM encoding and stream field widths for the boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int CSUM_W         = 8;
    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;
    localparam int WORD_W         = 32;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-to-word assembler with running data checksum.
// Emits a combinational word_done on the last byte of each word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic              o_word_done,
    output logic [WORD_W-1:0] o_word,
    output logic [CSUM_W-1:0] o_csum
);

    logic [LANE_W-1:0] r_lane;
    logic [23:0]       r_shift;
    logic [CSUM_W-1:0] r_csum;

    assign o_word_done = i_byte_en
                      && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign o_word      = {i_byte, r_shift};
    assign o_csum      = r_csum;

    // Shift bytes in little-endian order and accumulate the checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane  <= '0;
            r_shift <= '0;
            r_csum  <= '0;
        end else if (i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
            r_csum  <= '0;
        end else if (i_byte_en) begin
            r_lane  <= r_lane + 1'b1;
            r_shift <= {i_byte, r_shift[23:8]};
            r_csum  <= r_csum + i_byte;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Parses a length-prefixed, checksummed byte stream into word writes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [LEN_W:0] CAP =
        {{LEN_W{1'b0}}, 1'b1} << ADDR_WIDTH;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [WORD_W-1:0]     r_imem_wdata;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_err;
    logic [LEN_W:0]        r_len;
    logic [LEN_W:0]        r_widx;

    logic                  w_xfer;
    logic                  w_clear;
    logic                  w_byte_en;
    logic                  w_word_done;
    logic [WORD_W-1:0]     w_word;
    logic [CSUM_W-1:0]     w_csum;
    logic [LEN_W:0]        w_n;
    logic [LEN_W:0]        w_widx_nxt;

    // restart wins over a coincident transfer
    assign w_xfer     = in_valid && r_in_ready && !restart;
    assign w_clear    = restart || (r_state == S_LEN_LO);
    assign w_byte_en  = w_xfer && (r_state == S_DATA);
    assign w_n        = {1'b0, in_data, r_len[7:0]};
    assign w_widx_nxt = r_widx + 1'b1;

    word_assembler u_asm (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_clear),
        .i_byte_en   (w_byte_en),
        .i_byte      (in_data),
        .o_word_done (w_word_done),
        .o_word      (w_word),
        .o_csum      (w_csum)
    );

    // Load FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LEN_LO;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= '0;
            r_widx       <= '0;
        end else if (restart) begin
            r_state    <= S_LEN_LO;
            r_in_ready <= 1'b1;
            r_imem_we  <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
            r_widx     <= '0;
        end else begin
            r_imem_we <= 1'b0;
            unique case (r_state)
                S_LEN_LO: begin
                    r_in_ready <= 1'b1;
                    r_widx     <= '0;
                    if (w_xfer) begin
                        r_len   <= {{(LEN_W-7){1'b0}}, in_data};
                        r_state <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len <= w_n;
                        if (w_n > CAP) begin
                            r_state    <= S_ERROR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else if (w_n == '0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_done) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= BASE + r_widx[ADDR_WIDTH-1:0];
                        r_imem_wdata <= w_word;
                        r_widx       <= w_widx_nxt;
                        if (w_widx_nxt == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (in_data == w_csum) begin
                            r_state    <= S_DONE;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_in_ready <= 1'b0;
                end
                S_ERROR: begin
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;

endmodule
